// File: rtl/ex_mdu_if.sv
// ex_mdu_if: issue/result bundle between the EX stage and the iterative
// multiply/divide unit.
//   master (EX side) : drives mdu_valid_i, mdu_op_i, rs1/rs2 operands,
//                      flush_i, mdu_res_ready_i; observes ready/busy/result.
//   slave  (MDU side): the mirror image.
interface ex_mdu_if #(
  parameter int XLEN = 32
);
  logic            mdu_valid_i;
  logic [2:0]      mdu_op_i;
  logic [XLEN-1:0] rs1_rdata_i;
  logic [XLEN-1:0] rs2_rdata_i;
  logic            flush_i;
  logic            mdu_res_ready_i;
  logic            mdu_ready_o;
  logic            mdu_busy_o;
  logic            mdu_res_valid_o;
  logic [XLEN-1:0] mdu_res_o;

  modport master (
    output mdu_valid_i, mdu_op_i, rs1_rdata_i, rs2_rdata_i, flush_i, mdu_res_ready_i,
    input  mdu_ready_o, mdu_busy_o, mdu_res_valid_o, mdu_res_o
  );

  modport slave (
    input  mdu_valid_i, mdu_op_i, rs1_rdata_i, rs2_rdata_i, flush_i, mdu_res_ready_i,
    output mdu_ready_o, mdu_busy_o, mdu_res_valid_o, mdu_res_o
  );
endinterface

// File: rtl/ex_mdu.sv
// ex_mdu: iterative RV M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/
// REM/REMU). Radix-2 shift-add multiplier and restoring divider working on
// operand magnitudes; signs are re-applied when the result is captured.
// Divide-by-zero and signed overflow complete one cycle after accept.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   mdu  - ex_mdu_if.slave: issue (valid/op/rs1/rs2), flush, result
//          handshake (res_valid/res/res_ready), ready and busy status
module ex_mdu #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  ex_mdu_if.slave  mdu
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [1:0]        kind, kind_next;          // funct3[1:0]: selects result half / quo vs rem
  logic              neg, neg_next;            // product/quotient must be negated
  logic              sign_rem, sign_rem_next;  // dividend sign, given to the remainder
  logic [2*XLEN-1:0] opa, opa_next;            // shifted multiplicand
  logic [XLEN-1:0]   opb, opb_next;            // multiplier (shifts right) or divisor
  logic [2*XLEN-1:0] acc, acc_next;            // product, or {remainder, quotient}
  logic [XLEN-1:0]   res, res_next;

  logic [2:0]        op;
  logic [XLEN-1:0]   rs1, rs2;
  logic              accept, a_signed, b_signed, sign_a, sign_b, div_ovf, last;
  logic [XLEN-1:0]   a_mag, b_mag, quo, rem;
  logic [2*XLEN-1:0] mul_sum, prod, div_acc;
  logic [XLEN:0]     trial;

  assign op  = mdu.mdu_op_i;
  assign rs1 = mdu.rs1_rdata_i;
  assign rs2 = mdu.rs2_rdata_i;

  assign accept   = mdu.mdu_valid_i & (state == IDLE) & ~mdu.flush_i;
  // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM.
  assign a_signed = (op == 3'b001) | (op == 3'b010) | (op[2] & ~op[0]);
  assign b_signed = (op == 3'b001) | (op[2] & ~op[0]);
  assign sign_a   = a_signed & rs1[XLEN-1];
  assign sign_b   = b_signed & rs2[XLEN-1];
  // The most negative value maps onto itself, which is its correct magnitude.
  assign a_mag    = sign_a ? -rs1 : rs1;
  assign b_mag    = sign_b ? -rs2 : rs2;
  assign div_ovf  = op[2] & ~op[0] & (rs1 == MIN_NEG) & (rs2 == '1);
  assign last     = (cnt == CNT_W'(XLEN - 1));

  // One multiply step and its sign-corrected final value.
  assign mul_sum = acc + (opb[0] ? opa : '0);
  assign prod    = neg ? -mul_sum : mul_sum;

  // One restoring divide step: {rem,quo} << 1, then trial-subtract the
  // divisor from the widened partial remainder; a borrow keeps the shift.
  assign trial   = acc[2*XLEN-1:XLEN-1] - {1'b0, opb};
  assign div_acc = trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                               : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  assign quo     = neg      ? -div_acc[XLEN-1:0]      : div_acc[XLEN-1:0];
  assign rem     = sign_rem ? -div_acc[2*XLEN-1:XLEN] : div_acc[2*XLEN-1:XLEN];

  // NOTE: every target gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    kind_next     = kind;
    neg_next      = neg;
    sign_rem_next = sign_rem;
    opa_next      = opa;
    opb_next      = opb;
    acc_next      = acc;
    res_next      = res;

    case (state)
      IDLE: begin
        if (accept) begin
          kind_next     = op[1:0];
          neg_next      = sign_a ^ sign_b;
          sign_rem_next = sign_a;
          opa_next      = {{XLEN{1'b0}}, a_mag};
          opb_next      = b_mag;
          acc_next      = op[2] ? {{XLEN{1'b0}}, a_mag} : '0;
          cnt_next      = '0;
          if (!op[2]) begin
            state_next = MUL;
          end else if (rs2 == '0) begin
            state_next = DONE;
            res_next   = op[1] ? rs1 : '1;
          end else if (div_ovf) begin
            state_next = DONE;
            res_next   = op[1] ? '0 : rs1;
          end else begin
            state_next = DIV;
          end
        end
      end
      MUL: begin
        acc_next = mul_sum;
        opa_next = opa << 1;
        opb_next = opb >> 1;
        cnt_next = cnt + CNT_W'(1);
        if (last) begin
          state_next = DONE;
          res_next   = (kind == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
      end
      DIV: begin
        acc_next = div_acc;
        cnt_next = cnt + CNT_W'(1);
        if (last) begin
          state_next = DONE;
          res_next   = kind[1] ? rem : quo;
        end
      end
      DONE: begin
        if (mdu.mdu_res_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Flush wins over accept and over the result handshake.
    if (mdu.flush_i) state_next = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      kind     <= '0;
      neg      <= 1'b0;
      sign_rem <= 1'b0;
      opa      <= '0;
      opb      <= '0;
      acc      <= '0;
      res      <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      kind     <= kind_next;
      neg      <= neg_next;
      sign_rem <= sign_rem_next;
      opa      <= opa_next;
      opb      <= opb_next;
      acc      <= acc_next;
      res      <= res_next;
    end
  end

  assign mdu.mdu_ready_o     = (state == IDLE);
  assign mdu.mdu_busy_o      = (state != IDLE);
  assign mdu.mdu_res_valid_o = (state == DONE);
  assign mdu.mdu_res_o       = res;

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: directed bench for ex_mdu (XLEN=32). Expected results are
// queued when an op is issued and popped when the unit presents a result.
module tb_ex_mdu;

  localparam int XLEN = 32;
  localparam int MAX_WAIT = 100;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [XLEN-1:0] exp_q[$];

  ex_mdu_if #(.XLEN(XLEN)) mdu_bus ();

  ex_mdu #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .mdu (mdu_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op at a negedge, wait for the result, check latency, value,
  // and (for hold > 0) stability under backpressure, then hand it off.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp, input int lat, input int hold);
    int k;
    bit busy_ok;
    logic [XLEN-1:0] want;
    mdu_bus.mdu_valid_i = 1'b1;
    mdu_bus.mdu_op_i    = op;
    mdu_bus.rs1_rdata_i = a;
    mdu_bus.rs2_rdata_i = b;
    exp_q.push_back(exp);
    @(negedge clk);
    mdu_bus.mdu_valid_i = 1'b0;
    mdu_bus.rs1_rdata_i = $urandom;
    mdu_bus.rs2_rdata_i = $urandom;
    k = 1;
    busy_ok = 1'b1;
    while (!mdu_bus.mdu_res_valid_o && k < MAX_WAIT) begin
      busy_ok &= mdu_bus.mdu_busy_o;
      @(negedge clk);
      k++;
    end
    want = exp_q.pop_front();
    check({tag, "_latency"}, 64'(k), 64'(lat));
    check({tag, "_busy"}, {63'd0, busy_ok & mdu_bus.mdu_busy_o & ~mdu_bus.mdu_ready_o}, 64'd1);
    check({tag, "_result"}, 64'(mdu_bus.mdu_res_o), 64'(want));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_res"}, 64'(mdu_bus.mdu_res_o), 64'(want));
      check({tag, "_hold_valid_ready"},
            {62'd0, mdu_bus.mdu_res_valid_o, mdu_bus.mdu_ready_o}, 64'b10);
    end
    mdu_bus.mdu_res_ready_i = 1'b1;
    @(negedge clk);
    mdu_bus.mdu_res_ready_i = 1'b0;
    check({tag, "_back_idle"},
          {61'd0, mdu_bus.mdu_ready_o, mdu_bus.mdu_busy_o, mdu_bus.mdu_res_valid_o}, 64'b100);
  endtask

  initial begin
    bit saw_valid;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    mdu_bus.mdu_valid_i     = 1'b0;
    mdu_bus.mdu_op_i        = '0;
    mdu_bus.rs1_rdata_i     = '0;
    mdu_bus.rs2_rdata_i     = '0;
    mdu_bus.flush_i         = 1'b0;
    mdu_bus.mdu_res_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ready", 64'(mdu_bus.mdu_ready_o), 64'd1);
    check("reset_busy", 64'(mdu_bus.mdu_busy_o), 64'd0);
    check("reset_valid", 64'(mdu_bus.mdu_res_valid_o), 64'd0);
    check("reset_res", 64'(mdu_bus.mdu_res_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Multiplies: full 33-cycle latency.
    run_op("mul_7_m3",      OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
    run_op("mulh_min_min",  OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0);
    run_op("mulhu_8_8",     OP_MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0);
    run_op("mulhsu_min_8",  OP_MULHSU, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 33, 0);
    run_op("mulhu_ff_ff",   OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);

    // Divides.
    run_op("div_m7_2",      OP_DIV,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
    run_op("rem_m7_2",      OP_REM,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
    run_op("divu_100_7",    OP_DIVU,   32'd100, 32'd7, 32'd14, 33, 0);
    run_op("remu_100_7",    OP_REMU,   32'd100, 32'd7, 32'd2, 33, 0);

    // Early-completion special cases.
    run_op("divu_by_0",     OP_DIVU,   32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op("remu_by_0",     OP_REMU,   32'd5, 32'd0, 32'd5, 1, 0);
    run_op("div_ovf",       OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("rem_ovf",       OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);

    // Backpressure: result held 5 cycles with ready low.
    run_op("mul_backpressure", OP_MUL, 32'd6, 32'd7, 32'd42, 33, 5);

    // Flush during a divide: no result, unit idle next cycle.
    mdu_bus.mdu_valid_i = 1'b1;
    mdu_bus.mdu_op_i    = OP_DIV;
    mdu_bus.rs1_rdata_i = 32'd1000;
    mdu_bus.rs2_rdata_i = 32'd3;
    @(negedge clk);
    mdu_bus.mdu_valid_i = 1'b0;
    repeat (10) @(negedge clk);
    check("flush_pre_busy", 64'(mdu_bus.mdu_busy_o), 64'd1);
    mdu_bus.flush_i = 1'b1;
    @(negedge clk);
    mdu_bus.flush_i = 1'b0;
    check("flush_idle",
          {61'd0, mdu_bus.mdu_ready_o, mdu_bus.mdu_busy_o, mdu_bus.mdu_res_valid_o}, 64'b100);
    saw_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw_valid |= mdu_bus.mdu_res_valid_o;
    end
    check("flush_no_valid", 64'(saw_valid), 64'd0);
    run_op("mul_after_flush", OP_MUL, 32'd3, 32'd4, 32'd12, 33, 0);

    // Reset in the middle of a multiply.
    mdu_bus.mdu_valid_i = 1'b1;
    mdu_bus.mdu_op_i    = OP_MUL;
    mdu_bus.rs1_rdata_i = 32'd9;
    mdu_bus.rs2_rdata_i = 32'd9;
    @(negedge clk);
    mdu_bus.mdu_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_outputs",
          {61'd0, mdu_bus.mdu_ready_o, mdu_bus.mdu_busy_o, mdu_bus.mdu_res_valid_o}, 64'b100);
    check("rst_mid_res", 64'(mdu_bus.mdu_res_o), 64'd0);

    // Flush together with valid in IDLE: op must not be taken.
    mdu_bus.mdu_valid_i = 1'b1;
    mdu_bus.flush_i     = 1'b1;
    mdu_bus.mdu_op_i    = OP_MUL;
    @(negedge clk);
    mdu_bus.mdu_valid_i = 1'b0;
    mdu_bus.flush_i     = 1'b0;
    check("collide_ready_busy", {62'd0, mdu_bus.mdu_ready_o, mdu_bus.mdu_busy_o}, 64'b10);
    @(negedge clk);
    check("collide_still_idle",
          {61'd0, mdu_bus.mdu_ready_o, mdu_bus.mdu_busy_o, mdu_bus.mdu_res_valid_o}, 64'b100);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
Iterative multiply/divide unit for the execute stage. It implements the RV M-extension ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU), parametrised in XLEN. It sits beside the single-cycle ALU: EX issues one op, stalls while the unit is busy, and takes the result into the ALU-result path toward MEM. It uses a radix-2 shift-add multiplier and a restoring divider, with early completion for divide special cases.

Parameters:
XLEN, 32, operand/result width; any even value >= 8.
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset.
mdu_valid_i  input  1  EX presents an M-op this cycle.
mdu_op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
rs1_rdata_i  input  XLEN  operand A (multiplicand/dividend).
rs2_rdata_i  input  XLEN  operand B (multiplier/divisor).
flush_i  input  1  pipeline flush; abort any op.
mdu_res_ready_i  input  1  EX/MEM accepts result.
mdu_ready_o  output  1  unit idle, can accept.
mdu_busy_o  output  1  op in flight or result pending (EX stall request).
mdu_res_valid_o  output  1  result valid.
mdu_res_o  output  XLEN  result.

Behaviour:
- Clock and reset: one clock (clk); reset synchronous, active-high (rst).
- Reset values:
  - State IDLE; counter 0; operand/accumulator registers 0.
  - mdu_ready_o=1, mdu_busy_o=0, mdu_res_valid_o=0, mdu_res_o=0.
- FSM states IDLE, MUL, DIV, DONE:
  - mdu_ready_o = (state==IDLE).
  - mdu_busy_o = (state!=IDLE).
  - mdu_res_valid_o = (state==DONE).
- Accept: mdu_valid_i & mdu_ready_o & ~flush_i. On accept, latch the op, sign flags and operand magnitudes.
  - Signed operands are rs1 for MULH/MULHSU/DIV/REM and rs2 for MULH/DIV/REM; they are absolute-valued.
  - Next state is MUL for op[2]=0, otherwise DIV.
- Divide special cases, detected at accept; next state is DONE directly (result valid 1 cycle after accept):
  - Divisor 0: quotient all-ones; remainder = rs1.
  - Signed overflow (DIV/REM, rs1 = 1<<(XLEN-1), rs2 = all-ones): quotient = rs1; remainder 0.
- MUL state:
  - Each cycle: if multiplier LSB, add multiplicand (shifted) into a 2*XLEN product; shift multiplier right.
  - XLEN iterations (counter 0..XLEN-1), then DONE.
- DIV state:
  - Restoring: shift {rem,quo} left by 1; trial-subtract divisor; on non-negative keep the difference and set quotient LSB.
  - XLEN iterations, then DONE.
- Normal latency: accept at cycle T, mdu_res_valid_o high at T+XLEN+1 (33 for XLEN=32).
- Sign fix, applied when entering DONE; result register is loaded once and stable in DONE:
  - Product negated if signA^signB.
  - Quotient negated if signA^signB.
  - Remainder takes the sign of the dividend.
- Result select:
  - MUL: product[XLEN-1:0].
  - MULH/MULHSU/MULHU: product[2*XLEN-1:XLEN].
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- DONE: holds mdu_res_o and mdu_res_valid_o until mdu_res_ready_i=1, then IDLE next cycle. No accept in the same cycle as result handshake (one idle cycle between ops).
- flush_i:
  - From any state, next state is IDLE and mdu_res_valid_o=0 next cycle; the in-flight result is discarded.
  - Flush has priority over accept and over result handshake in the same cycle.
- mdu_valid_i while busy: ignored (no queue); EX holds the op via the stall.
- rst mid-operation: same as the reset values above; no partial result emitted.
- Operand inputs are don't-care except in the accept cycle.

Test Plan:
- MUL: rs1=7, rs2=0xFFFFFFFD -> mdu_res_o=0xFFFFFFEB, valid exactly 33 cycles after accept; busy high throughout.
- High-word products with rs1=0x80000000:
  - MULH, rs2=0x80000000 -> 0x40000000.
  - MULHU, rs2=0x80000000 -> 0x40000000.
  - MULHSU, rs2=0x80000000 -> 0xC0000000.
  - MULHU, rs1=rs2=0xFFFFFFFF -> 0xFFFFFFFE.
- Signed divide, rs1=0xFFFFFFF9 (-7), rs2=2:
  - DIV -> 0xFFFFFFFD.
  - REM -> 0xFFFFFFFF.
  - DIVU rs1=100, rs2=7 -> 14; REMU -> 2. All valid at accept+33.
- Special cases:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
  - Each valid 1 cycle after accept.
- Backpressure and flush:
  - Hold mdu_res_ready_i=0 for 5 cycles in DONE -> result and valid stable, ready_o=0.
  - Assert flush_i at iteration 10 of a DIV -> IDLE next cycle, no valid pulse; next MUL 3*4 returns 12.
- Reset and collision:
  - Assert rst mid-MUL -> all outputs return to reset values next cycle.
  - flush_i together with mdu_valid_i in IDLE -> op not accepted, ready_o stays 1.
